div_unit: RTL and testbench

- Sequential signed 32-bit divider for the multicycle MIPS datapath. It sits directly downstream of the control unit.
- Started by the control unit's DivCtrl pulse. Takes operands from the A/B register outputs.
- Produces quotient (to LO) and remainder (to HI), plus a divide-by-zero flag that feeds the exception path (ExceptionCtrl).
- The control unit waits on DivDone before asserting WriteHI/WriteLO.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 23 ++
 rtl/div_unit.sv | 111 +++++++++++
 tb/tb_div_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential signed divider.
package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_ITER  = 32;
   localparam int DIV_CNT_W = 5;

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_ITER    = 2'b01,
      S_SIGNFIX = 2'b10,
      S_DONE    = 2'b11
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] dq_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] dq_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           ge;

   // One extra bit keeps the compare exact when the divisor is >= 2^(WIDTH-1)
   assign shifted = {rem_i, dq_i[WIDTH-1]};
   assign diff    = shifted - {1'b0, divisor_i};
   assign ge      = shifted >= {1'b0, divisor_i};
   assign rem_o   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign dq_o    = {dq_i[WIDTH-2:0], ge};

endmodule

// File: rtl/div_unit.sv
// Sequential signed divider: LO=quotient, HI=remainder, DivZero on B==0.
// Define DIV_DIVU_EN to add the DivUnsigned input for unsigned division.
module div_unit
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int ITER  = DIV_ITER
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             DivCtrl,
`ifdef DIV_DIVU_EN
   input  logic             DivUnsigned,
`endif
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             DivBusy,
   output logic             DivDone,
   output logic             DivZero
);

   div_state_e             state_q;
   logic [DIV_CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]       rem_q, dq_q, dvs_q, hi_q, lo_q;
   logic [WIDTH-1:0]       rem_d, dq_d;
   logic                   sa_q, sb_q, zero_q;
   logic                   busy_q, done_q, dz_q;
   logic                   uns;
   logic                   neg_a, neg_b;

`ifdef DIV_DIVU_EN
   assign uns = DivUnsigned;
`else
   assign uns = 1'b0;
`endif

   assign neg_a = A[WIDTH-1] & ~uns;
   assign neg_b = B[WIDTH-1] & ~uns;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .dq_i      (dq_q),
      .divisor_i (dvs_q),
      .rem_o     (rem_d),
      .dq_o      (dq_d)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dq_q    <= '0;
         dvs_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               dz_q   <= 1'b0;
               if (DivCtrl) begin
                  sa_q    <= neg_a;
                  sb_q    <= neg_b;
                  dq_q    <= neg_a ? -A : A;
                  dvs_q   <= neg_b ? -B : B;
                  rem_q   <= '0;
                  cnt_q   <= DIV_CNT_W'(ITER - 1);
                  busy_q  <= 1'b1;
                  zero_q  <= (B == '0);
                  state_q <= (B == '0) ? S_DONE : S_ITER;
               end
            end
            S_ITER: begin
               rem_q <= rem_d;
               dq_q  <= dq_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) state_q <= S_SIGNFIX;
            end
            S_SIGNFIX: begin
               // Truncating semantics: remainder takes the dividend's sign
               lo_q    <= (sa_q ^ sb_q) ? -dq_q : dq_q;
               hi_q    <= sa_q ? -rem_q : rem_q;
               state_q <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b1;
               dz_q    <= zero_q;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign HI      = hi_q;
   assign LO      = lo_q;
   assign DivBusy = busy_q;
   assign DivDone = done_q;
   assign DivZero = dz_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes expected results, monitor checks on DivDone.
module tb_div_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        DivCtrl = 1'b0;
   logic [31:0] A = '0, B = '0;
   logic [31:0] HI, LO;
   logic        DivBusy, DivDone, DivZero;
`ifdef DIV_DIVU_EN
   logic        DivUnsigned = 1'b0;
`endif

   div_unit dut (
      .clock   (clock),
      .reset   (reset),
      .DivCtrl (DivCtrl),
`ifdef DIV_DIVU_EN
      .DivUnsigned (DivUnsigned),
`endif
      .A       (A),
      .B       (B),
      .HI      (HI),
      .LO      (LO),
      .DivBusy (DivBusy),
      .DivDone (DivDone),
      .DivZero (DivZero)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          due;
   } exp_t;

   exp_t        sbq[$];
   int          passed = 0;
   int          total  = 0;
   logic [31:0] m_hi = '0, m_lo = '0;
   logic        prev_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic bad(input string msg);
      total++;
      $display("FAIL %s", msg);
   endtask

   // Reference: plain 64-bit signed arithmetic, truncating toward zero
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input int n, output exp_t e);
      longint sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (b == 32'd0) begin
         e.dz  = 1'b1;
         e.due = n + 1;
      end else begin
         q    = sa / sb;
         r    = sa % sb;
         m_lo = q[31:0];
         m_hi = r[31:0];
         e.dz  = 1'b0;
         e.due = n + 34;
      end
      e.hi = m_hi;
      e.lo = m_lo;
   endfunction

   task automatic start(input logic [31:0] a, input logic [31:0] b, output int n);
      exp_t e;
      A = a; B = b; DivCtrl = 1'b1;
      @(negedge clock);
      DivCtrl = 1'b0;
      n = cyc;
      model(a, b, n, e);
      sbq.push_back(e);
      chk("busy_after_start", {31'd0, DivBusy}, 32'd1);
   endtask

   task automatic wait_done();
      int k = 0;
      while (sbq.size() != 0 && k < 80) begin
         @(negedge clock);
         k++;
      end
      if (sbq.size() != 0) begin
         bad($sformatf("timeout: DivDone not seen within 80 cycles, %0d pending", sbq.size()));
         sbq.delete();
      end
      @(negedge clock);
   endtask

   task automatic run(input logic [31:0] a, input logic [31:0] b);
      int n;
      start(a, b, n);
      wait_done();
   endtask

   always @(negedge clock) begin
      if (reset) begin
         if (DivDone) begin
            if (sbq.size() == 0) bad("unexpected DivDone with empty scoreboard");
            else begin
               exp_t e;
               e = sbq.pop_front();
               chk("LO", LO, e.lo);
               chk("HI", HI, e.hi);
               chk("DivZero", {31'd0, DivZero}, {31'd0, e.dz});
               chk("done_cycle", 32'(cyc), 32'(e.due));
               chk("busy_at_done", {31'd0, DivBusy}, 32'd0);
            end
            if (prev_done) bad("DivDone high for more than one cycle");
         end
         if (DivZero && !DivDone) bad("DivZero high without DivDone");
      end
      prev_done = DivDone;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] ra, rb;
      #1;
      chk("rst_HI", HI, 32'd0);
      chk("rst_LO", LO, 32'd0);
      chk("rst_busy", {31'd0, DivBusy}, 32'd0);
      chk("rst_done", {31'd0, DivDone}, 32'd0);
      chk("rst_zero", {31'd0, DivZero}, 32'd0);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      run(32'd7, 32'd2);
      run(32'hFFFF_FFF9, 32'd2);
      run(32'd7, 32'hFFFF_FFFE);
      run(32'h8000_0000, 32'hFFFF_FFFF);
      run(32'd5, 32'd2);
      run(32'd9, 32'd0);
      chk("busy_after_zero", {31'd0, DivBusy}, 32'd0);
      chk("HI_kept_after_zero", HI, 32'd1);
      chk("LO_kept_after_zero", LO, 32'd2);

      // Second DivCtrl while busy must be ignored
      start(32'd100, 32'd7, n);
      repeat (9) @(negedge clock);
      A = 32'd1; B = 32'd1; DivCtrl = 1'b1;
      @(negedge clock);
      DivCtrl = 1'b0;
      A = 32'hDEAD_BEEF; B = 32'h1234_5678;
      repeat (23) @(negedge clock);
      chk("LO_at_N33", LO, 32'd14);
      chk("HI_at_N33", HI, 32'd2);
      chk("done_low_at_N33", {31'd0, DivDone}, 32'd0);
      wait_done();

      // Asynchronous reset mid-operation
      start(32'd1000, 32'd3, n);
      repeat (14) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      chk("abort_HI", HI, 32'd0);
      chk("abort_LO", LO, 32'd0);
      chk("abort_busy", {31'd0, DivBusy}, 32'd0);
      chk("abort_done", {31'd0, DivDone}, 32'd0);
      sbq.delete();
      m_hi = '0; m_lo = '0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      run(32'd20, 32'd3);

      for (int i = 0; i < 30; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 4))
            0: rb = 32'($urandom_range(1, 15));
            1: rb = -32'($urandom_range(1, 15));
            2: rb = (i % 5 == 0) ? 32'd0 : $urandom;
            3: begin ra = 32'h8000_0000; rb = $urandom; end
            default: rb = $urandom;
         endcase
         run(ra, rb);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
